param_updown_counter: RTL and testbench
=======================================

Name: param_updown_counter

Overview:
- Parametrised successor to the team's free-running 8-bit up counter.
- Adds configurable width, up/down direction, programmable modulo limit, wrap or saturate mode, a tick prescaler, synchronous load/clear, a terminal-count pulse and a sticky overflow flag.
- Sits behind the top-level pin wrapper. The wrapper maps its pins onto these ports and drives `count` onto the dedicated outputs.

Parameters:
- WIDTH, 8, counter width in bits (legal range 2..32).
- PRESCALE_W, 4, width of the prescale divisor field (legal range 1..16).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- clear  input  1  synchronous clear of counter and prescaler.
- load  input  1  synchronous load of load_val.
- load_val  input  WIDTH  value applied on load.
- en  input  1  count enable; feeds the prescaler.
- up  input  1  direction: 1 = increment, 0 = decrement.
- sat_mode  input  1  1 = saturate at bounds, 0 = wrap.
- limit  input  WIDTH  upper bound; count range is 0..limit inclusive.
- prescale  input  PRESCALE_W  a step occurs every prescale+1 enabled cycles.
- ovf_clr  input  1  clears the sticky overflow flag.
- count  output  WIDTH  current counter value, registered.
- tc  output  1  terminal-count pulse, registered, one cycle wide.
- ovf  output  1  sticky boundary-event flag.

Behaviour:
- Reset:
  - Reset is asynchronous and active-high. Asserting `rst` immediately forces count=0, tc=0, ovf=0 and prescaler=0.
  - Release is synchronous to `clk`. No step occurs on the first edge after release unless `en` is high and prescale=0.
- Priority per edge: rst > clear > load > step.
  - clear: count←0, prescaler←0, tc←0. The ovf flag is untouched.
  - load: count←min(load_val, limit), prescaler←0, tc←0. A load never sets ovf.
- Prescaler:
  - Internal PRESCALE_W-bit counter; advances only when `en` is high.
  - On an enabled cycle with prescaler==prescale, a step fires and the prescaler resets to 0. Otherwise the prescaler increments.
  - With en=0 the prescaler holds its value.
  - prescale=0 gives one step per enabled cycle.
  - If `prescale` changes so that the prescaler exceeds it, the next enabled cycle fires a step and resets the prescaler.
- Step, up=1:
  - If count<limit: count←count+1.
  - If count≥limit (boundary event): wrap mode gives count←0; saturate mode gives count←limit.
- Step, up=0:
  - If count>limit (limit lowered under count): count←limit. This is not a boundary event.
  - Else if count>0: count←count−1.
  - Else (count==0, boundary event): wrap mode gives count←limit; saturate mode holds 0.
- tc:
  - tc=1 for exactly the one cycle after an edge on which a boundary event occurred; tc=0 otherwise.
  - In saturate mode, continued steps at the bound produce a tc pulse on each step.
- ovf:
  - Set by any boundary event; stays set until an edge with ovf_clr=1.
  - Set and clear on the same edge leaves ovf=1 (set wins).
- Arithmetic:
  - Unsigned, WIDTH bits, no carry out.
  - limit=0: count stays 0 and every step is a boundary event.
  - limit=all-ones: the full 2^WIDTH range.
- Outputs come directly from flops; no combinational path from inputs to outputs.
- The full design is one clock domain. The block adds no synchronisers; the wrapper guarantees all inputs are synchronous to clk.

Test Plan:
- Reset: rst pulse mid-count (count=0x37) asserted between edges → count=0, tc=0, ovf=0 before the next edge; after release with en=1, prescale=0, limit=0xFF, up=1, count reads 1,2,3 on successive edges.
- Wrap up: WIDTH=8, limit=9, prescale=0, up=1, en=1 from 0 → count 0..9 then 0. tc high only the cycle after 9→0; ovf=1 and stays set until ovf_clr; ovf_clr coincident with a boundary event keeps ovf=1.
- Saturate down with prescale: sat_mode=1, up=0, prescale=2, load_val=2 → count steps every 3 enabled cycles: 2,1,0, then holds 0 with a tc pulse every 3rd enabled cycle. Dropping en for 5 cycles freezes both count and prescaler.
- Priority: clear, load and a step-due cycle on the same edge → count=0. load=1 with load_val=0x50, limit=0x20 → count=0x20, no tc, ovf unchanged.
- Limit lowered: count=15, limit changed to 5. Up step gives 0 (wrap, tc=1) or 5 (saturate, tc=1); down step gives 5 with tc=0.
- WIDTH=16, limit=0xFFFF, up=1 from load_val=0xFFFE → 0xFFFF, then 0x0000 with tc=1.

Source files
------------

// File: rtl/param_updown_counter.sv
// Parametrised up/down counter with modulo limit, wrap/saturate, tick prescaler,
// synchronous clear/load, registered terminal-count pulse and sticky overflow.
module param_updown_counter #(
   parameter int unsigned WIDTH      = 8,
   parameter int unsigned PRESCALE_W = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clear,
   input  logic                  load,
   input  logic [WIDTH-1:0]      load_val,
   input  logic                  en,
   input  logic                  up,
   input  logic                  sat_mode,
   input  logic [WIDTH-1:0]      limit,
   input  logic [PRESCALE_W-1:0] prescale,
   input  logic                  ovf_clr,
   output logic [WIDTH-1:0]      count,
   output logic                  tc,
   output logic                  ovf
);

   logic [PRESCALE_W-1:0] presc_q;
   logic [PRESCALE_W-1:0] presc_d;
   logic [WIDTH-1:0]      count_d;
   logic [WIDTH-1:0]      step_val;
   logic                  step_due;
   logic                  boundary;
   logic                  tc_d;
   logic                  ovf_set;
   logic                  ovf_d;

   // >= rather than == so a prescale lowered under the running prescaler fires at once
   always_comb begin
      step_due = en && (presc_q >= prescale);
   end

   always_comb begin
      step_val = count;
      boundary = 1'b0;
      if (up) begin
         if (count < limit) begin
            step_val = count + WIDTH'(1);
         end else begin
            boundary = 1'b1;
            step_val = sat_mode ? limit : '0;
         end
      end else begin
         if (count > limit) begin
            step_val = limit;
         end else if (count != '0) begin
            step_val = count - WIDTH'(1);
         end else begin
            boundary = 1'b1;
            step_val = sat_mode ? '0 : limit;
         end
      end
   end

   always_comb begin
      count_d = count;
      presc_d = presc_q;
      tc_d    = 1'b0;
      ovf_set = 1'b0;
      if (clear) begin
         count_d = '0;
         presc_d = '0;
      end else if (load) begin
         count_d = (load_val > limit) ? limit : load_val;
         presc_d = '0;
      end else if (en) begin
         if (step_due) begin
            presc_d = '0;
            count_d = step_val;
            tc_d    = boundary;
            ovf_set = boundary;
         end else begin
            presc_d = presc_q + PRESCALE_W'(1);
         end
      end
      // a boundary event on the same edge as ovf_clr keeps the flag set
      ovf_d = ovf_set | (ovf & ~ovf_clr);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count   <= '0;
         presc_q <= '0;
         tc      <= 1'b0;
         ovf     <= 1'b0;
      end else begin
         count   <= count_d;
         presc_q <= presc_d;
         tc      <= tc_d;
         ovf     <= ovf_d;
      end
   end

endmodule

// File: tb/tb_param_updown_counter.sv
// Directed bench for param_updown_counter: an 8-bit instance for most scenarios
// and a 16-bit instance for the full-range wrap.
module tb_param_updown_counter;

   logic        clk = 1'b0;
   logic        rst;
   logic        clear;
   logic        load;
   logic [7:0]  load_val;
   logic        en;
   logic        up;
   logic        sat_mode;
   logic [7:0]  limit;
   logic [3:0]  prescale;
   logic        ovf_clr;
   logic [7:0]  count;
   logic        tc;
   logic        ovf;

   logic [15:0] b_load_val;
   logic [15:0] b_limit;
   logic [15:0] b_count;
   logic        b_tc;
   logic        b_ovf;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   param_updown_counter #(.WIDTH(8), .PRESCALE_W(4)) dut (
      .clk(clk), .rst(rst), .clear(clear), .load(load), .load_val(load_val),
      .en(en), .up(up), .sat_mode(sat_mode), .limit(limit), .prescale(prescale),
      .ovf_clr(ovf_clr), .count(count), .tc(tc), .ovf(ovf)
   );

   param_updown_counter #(.WIDTH(16), .PRESCALE_W(4)) dut16 (
      .clk(clk), .rst(rst), .clear(clear), .load(load), .load_val(b_load_val),
      .en(en), .up(up), .sat_mode(sat_mode), .limit(b_limit), .prescale(prescale),
      .ovf_clr(ovf_clr), .count(b_count), .tc(b_tc), .ovf(b_ovf)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; clear = 1'b0; load = 1'b0; load_val = 8'h00; en = 1'b0; up = 1'b1;
      sat_mode = 1'b0; limit = 8'hFF; prescale = 4'd0; ovf_clr = 1'b0;
      b_load_val = 16'h0000; b_limit = 16'hFFFF;
      #3;
      n_tests++;
      if (count !== 8'h00 || tc !== 1'b0 || ovf !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_state: got count=%h tc=%b ovf=%b, expected 00 0 0", count, tc, ovf);
      end
      tick();
      tick();
      rst = 1'b0;
      load_val = 8'hFF; load = 1'b1;
      tick();
      load = 1'b0; en = 1'b1;
      tick();
      n_tests++;
      if (count !== 8'h00 || tc !== 1'b1 || ovf !== 1'b1) begin
         n_fail++;
         $display("FAIL pre_reset_wrap: got count=%h tc=%b ovf=%b, expected 00 1 1", count, tc, ovf);
      end
      en = 1'b0; load_val = 8'h37; load = 1'b1;
      tick();
      n_tests++;
      if (count !== 8'h37 || ovf !== 1'b1) begin
         n_fail++;
         $display("FAIL pre_reset_load: got count=%h ovf=%b, expected 37 1", count, ovf);
      end
      load = 1'b0; en = 1'b1;
      rst = 1'b1;
      #2;
      n_tests++;
      if (count !== 8'h00 || tc !== 1'b0 || ovf !== 1'b0) begin
         n_fail++;
         $display("FAIL async_reset: got count=%h tc=%b ovf=%b, expected 00 0 0", count, tc, ovf);
      end
      #1;
      rst = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         tick();
         n_tests++;
         if (count !== 8'(i)) begin
            n_fail++;
            $display("FAIL post_reset_count: got %h expected %h", count, 8'(i));
         end
      end
      en = 1'b0;
   endtask

   task automatic test_wrap_up();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      limit = 8'd9; prescale = 4'd0; up = 1'b1; sat_mode = 1'b0; en = 1'b1;
      for (int i = 1; i <= 9; i++) begin
         tick();
         n_tests++;
         if (count !== 8'(i) || tc !== 1'b0 || ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_count: got count=%h tc=%b ovf=%b, expected %h 0 0", count, tc, ovf, 8'(i));
         end
      end
      tick();
      n_tests++;
      if (count !== 8'd0 || tc !== 1'b1 || ovf !== 1'b1) begin
         n_fail++;
         $display("FAIL wrap_edge: got count=%h tc=%b ovf=%b, expected 00 1 1", count, tc, ovf);
      end
      tick();
      n_tests++;
      if (count !== 8'd1 || tc !== 1'b0 || ovf !== 1'b1) begin
         n_fail++;
         $display("FAIL wrap_after: got count=%h tc=%b ovf=%b, expected 01 0 1", count, tc, ovf);
      end
      en = 1'b0;
      tick();
      n_tests++;
      if (ovf !== 1'b1) begin
         n_fail++;
         $display("FAIL ovf_sticky: got %b expected 1", ovf);
      end
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      n_tests++;
      if (ovf !== 1'b0) begin
         n_fail++;
         $display("FAIL ovf_clear: got %b expected 0", ovf);
      end
      load_val = 8'd9; load = 1'b1;
      tick();
      load = 1'b0; en = 1'b1; ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0; en = 1'b0;
      n_tests++;
      if (count !== 8'd0 || tc !== 1'b1 || ovf !== 1'b1) begin
         n_fail++;
         $display("FAIL ovf_set_wins: got count=%h tc=%b ovf=%b, expected 00 1 1", count, tc, ovf);
      end
   endtask

   task automatic test_sat_down();
      logic [7:0] exp_cnt [10] = '{8'd2, 8'd2, 8'd1, 8'd1, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
      logic       exp_tc  [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      sat_mode = 1'b1; up = 1'b0; prescale = 4'd2; limit = 8'd9;
      ovf_clr = 1'b1; load_val = 8'd2; load = 1'b1;
      tick();
      ovf_clr = 1'b0; load = 1'b0; en = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         n_tests++;
         if (count !== exp_cnt[i] || tc !== exp_tc[i]) begin
            n_fail++;
            $display("FAIL sat_down[%0d]: got count=%h tc=%b, expected %h %b", i, count, tc, exp_cnt[i], exp_tc[i]);
         end
      end
      n_tests++;
      if (ovf !== 1'b1) begin
         n_fail++;
         $display("FAIL sat_down_ovf: got %b expected 1", ovf);
      end
      en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         n_tests++;
         if (count !== 8'd0 || tc !== 1'b0) begin
            n_fail++;
            $display("FAIL en_freeze[%0d]: got count=%h tc=%b, expected 00 0", i, count, tc);
         end
      end
      en = 1'b1;
      tick();
      n_tests++;
      if (tc !== 1'b0) begin
         n_fail++;
         $display("FAIL presc_hold_a: got tc=%b expected 0", tc);
      end
      tick();
      n_tests++;
      if (tc !== 1'b1 || count !== 8'd0) begin
         n_fail++;
         $display("FAIL presc_hold_b: got count=%h tc=%b, expected 00 1", count, tc);
      end
      en = 1'b0;
   endtask

   task automatic test_priority();
      sat_mode = 1'b0; up = 1'b1; prescale = 4'd0; limit = 8'hFF;
      load_val = 8'h10; load = 1'b1;
      tick();
      clear = 1'b1; load = 1'b1; load_val = 8'h44; en = 1'b1;
      tick();
      clear = 1'b0; load = 1'b0;
      n_tests++;
      if (count !== 8'h00 || tc !== 1'b0 || ovf !== 1'b1) begin
         n_fail++;
         $display("FAIL clear_prio: got count=%h tc=%b ovf=%b, expected 00 0 1", count, tc, ovf);
      end
      load_val = 8'h50; limit = 8'h20; load = 1'b1;
      tick();
      n_tests++;
      if (count !== 8'h20 || tc !== 1'b0 || ovf !== 1'b1) begin
         n_fail++;
         $display("FAIL load_clamp: got count=%h tc=%b ovf=%b, expected 20 0 1", count, tc, ovf);
      end
      load = 1'b0; en = 1'b0; ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      load_val = 8'h20; load = 1'b1; en = 1'b1;
      tick();
      load = 1'b0; en = 1'b0;
      n_tests++;
      if (count !== 8'h20 || tc !== 1'b0 || ovf !== 1'b0) begin
         n_fail++;
         $display("FAIL load_over_step: got count=%h tc=%b ovf=%b, expected 20 0 0", count, tc, ovf);
      end
   endtask

   task automatic test_limit_lowered();
      prescale = 4'd0; en = 1'b0; limit = 8'hFF; load_val = 8'd15; load = 1'b1;
      tick();
      load = 1'b0; limit = 8'd5; up = 1'b1; sat_mode = 1'b0; en = 1'b1;
      tick();
      en = 1'b0;
      n_tests++;
      if (count !== 8'd0 || tc !== 1'b1) begin
         n_fail++;
         $display("FAIL lowered_up_wrap: got count=%h tc=%b, expected 00 1", count, tc);
      end
      limit = 8'hFF; load = 1'b1;
      tick();
      load = 1'b0; limit = 8'd5; sat_mode = 1'b1; en = 1'b1;
      tick();
      en = 1'b0;
      n_tests++;
      if (count !== 8'd5 || tc !== 1'b1) begin
         n_fail++;
         $display("FAIL lowered_up_sat: got count=%h tc=%b, expected 05 1", count, tc);
      end
      limit = 8'hFF; load = 1'b1; ovf_clr = 1'b1;
      tick();
      load = 1'b0; ovf_clr = 1'b0; limit = 8'd5; up = 1'b0; en = 1'b1;
      tick();
      en = 1'b0;
      n_tests++;
      if (count !== 8'd5 || tc !== 1'b0 || ovf !== 1'b0) begin
         n_fail++;
         $display("FAIL lowered_down: got count=%h tc=%b ovf=%b, expected 05 0 0", count, tc, ovf);
      end
   endtask

   task automatic test_limit_zero();
      clear = 1'b1;
      tick();
      clear = 1'b0; limit = 8'd0; up = 1'b1; sat_mode = 1'b0; prescale = 4'd0; en = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         n_tests++;
         if (count !== 8'd0 || tc !== 1'b1) begin
            n_fail++;
            $display("FAIL limit_zero[%0d]: got count=%h tc=%b, expected 00 1", i, count, tc);
         end
      end
      en = 1'b0;
   endtask

   task automatic test_wide();
      b_limit = 16'hFFFF; b_load_val = 16'hFFFE; load = 1'b1; en = 1'b0;
      tick();
      load = 1'b0; up = 1'b1; sat_mode = 1'b0; prescale = 4'd0; en = 1'b1;
      tick();
      n_tests++;
      if (b_count !== 16'hFFFF || b_tc !== 1'b0) begin
         n_fail++;
         $display("FAIL wide_top: got count=%h tc=%b, expected ffff 0", b_count, b_tc);
      end
      tick();
      en = 1'b0;
      n_tests++;
      if (b_count !== 16'h0000 || b_tc !== 1'b1 || b_ovf !== 1'b1) begin
         n_fail++;
         $display("FAIL wide_wrap: got count=%h tc=%b ovf=%b, expected 0000 1 1", b_count, b_tc, b_ovf);
      end
   endtask

   initial begin
      test_reset();
      test_wrap_up();
      test_sat_down();
      test_priority();
      test_limit_lowered();
      test_limit_zero();
      test_wide();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
